// File: rtl/hex_key_controller.sv
// hex_key_controller: debounces scanner Code/Valid pairs into one event per
// physical key press and queues those events in a small FIFO that the
// consumer drains with a pop handshake. A sticky overflow flag records any
// press that was lost because the queue was full.
module hex_key_controller #(
    parameter int DEBOUNCE_CYCLES = 4,  // 2..255 identical samples to accept a press/release
    parameter int FIFO_DEPTH      = 4   // power of two, 2..16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [3:0]                    Code,
    input  logic                          Valid,
    input  logic                          key_pop,
    input  logic                          clear_ovf,
    output logic [3:0]                    key_data,
    output logic                          key_avail,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [7:0]    DEB_LIMIT = 8'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [7:0]    cnt, cnt_nxt, cnt_inc;
    logic [3:0]    cand, cand_nxt;
    logic          push_req;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          is_full, is_empty;
    logic          do_push, do_pop, drop;

    assign cnt_inc = cnt + 8'd1;

    // Debounce FSM next-state logic: qualify a press, hold it, qualify the release.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        push_req  = 1'b0;
        case (state)
            IDLE: begin
                if (Valid) begin
                    cand_nxt  = Code;
                    cnt_nxt   = 8'd1;
                    state_nxt = CONFIRM;
                end
            end
            CONFIRM: begin
                if (Valid && (Code == cand)) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == DEB_LIMIT) begin
                        push_req  = 1'b1;
                        state_nxt = HELD;
                    end
                end else begin
                    // A mismatching sample is dropped, not taken as a new candidate.
                    state_nxt = IDLE;
                end
            end
            HELD: begin
                if (!Valid) begin
                    cnt_nxt   = 8'd1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!Valid) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == DEB_LIMIT) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    // Bounce during release returns to HELD without a new event.
                    state_nxt = HELD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Debounce FSM state registers.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            cand  <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    assign is_full  = (count == DEPTH_CNT);
    assign is_empty = (count == '0);

    // Pop on empty is ignored; a push into a full queue only succeeds when
    // the head is popped in the same cycle, freeing its slot.
    assign do_pop  = key_pop && !is_empty;
    assign do_push = push_req && (!is_full || key_pop);
    assign drop    = push_req && is_full && !key_pop;

    // Occupancy update from the push/pop pair.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Pointer width equals log2(depth), so increment wraps naturally.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            // A dropped push wins over a simultaneous clear.
            if (drop)           overflow <= 1'b1;
            else if (clear_ovf) overflow <= 1'b0;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clock) begin
        // NOTE: the storage array is deliberately not reset; the count gates
        // every read, so stale contents are never observed.
        if (do_push) mem[wr_ptr] <= cand;
    end

    assign key_avail  = !is_empty;
    assign fifo_full  = is_full;
    assign fifo_count = count;
    assign key_data   = is_empty ? 4'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_hex_key_controller.sv
// Self-checking bench for hex_key_controller (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// Expected key events go into a scoreboard queue when stimulus that should
// produce them is driven, and are popped and compared as the consumer drains.
module tb_hex_key_controller;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Code = 4'd0;
    logic       Valid = 1'b0;
    logic       key_pop = 1'b0;
    logic       clear_ovf = 1'b0;
    logic [3:0] key_data;
    logic       key_avail;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    logic [3:0] sb [$];

    typedef struct {
        logic [3:0] code;
        int         on_cycles;
        logic [2:0] exp_count;
    } vec_t;

    vec_t vecs [6];

    hex_key_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .Code      (Code),
        .Valid     (Valid),
        .key_pop   (key_pop),
        .clear_ovf (clear_ovf),
        .key_data  (key_data),
        .key_avail (key_avail),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] code, input int on_cycles, input int off_cycles);
        Code  = code;
        Valid = 1'b1;
        repeat (on_cycles) tick();
        Valid = 1'b0;
        repeat (off_cycles) tick();
    endtask

    // Compare the FIFO head against the scoreboard front, then pop it.
    task automatic pop_check(input string name);
        logic [3:0] exp;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 1, 0);
        end else begin
            exp = sb.pop_front();
            check({name, "_avail"}, key_avail, 1);
            check({name, "_data"}, key_data, exp);
            key_pop = 1'b1;
            tick();
            key_pop = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        while (sb.size() != 0) pop_check(name);
        check({name, "_empty_avail"}, key_avail, 0);
        check({name, "_empty_count"}, fifo_count, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_avail"}, key_avail, 0);
        check({name, "_full"}, fifo_full, 0);
        check({name, "_count"}, fifo_count, 0);
        check({name, "_ovf"}, overflow, 0);
        check({name, "_data"}, key_data, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{code: 4'hA, on_cycles: 3,  exp_count: 3'd0};
        vecs[1] = '{code: 4'hA, on_cycles: 1,  exp_count: 3'd0};
        vecs[2] = '{code: 4'h2, on_cycles: 4,  exp_count: 3'd1};
        vecs[3] = '{code: 4'h9, on_cycles: 10, exp_count: 3'd1};
        vecs[4] = '{code: 4'hC, on_cycles: 2,  exp_count: 3'd0};
        vecs[5] = '{code: 4'hE, on_cycles: 5,  exp_count: 3'd1};

        // Reset state.
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Clean press of 7: event becomes visible right after edge 4.
        Code  = 4'h7;
        Valid = 1'b1;
        repeat (3) tick();
        check("clean_avail_e3", key_avail, 0);
        tick();
        check("clean_avail_e4", key_avail, 1);
        check("clean_data_e4", key_data, 4'h7);
        check("clean_count_e4", fifo_count, 1);
        sb.push_back(4'h7);
        repeat (6) tick();
        Valid = 1'b0;
        repeat (6) tick();
        check("clean_count_final", fifo_count, 1);
        drain("clean");

        // Table of single presses of varying length.
        foreach (vecs[i]) begin
            press(vecs[i].code, vecs[i].on_cycles, 6);
            check($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_count);
            if (vecs[i].exp_count != 0) sb.push_back(vecs[i].code);
            drain($sformatf("vec%0d", i));
        end

        // Bounce reject: 3 on / 1 off five times, then a solid 4-cycle hold.
        for (int i = 0; i < 5; i++) press(4'hA, 3, 1);
        check("bounce_no_event", key_avail, 0);
        Code  = 4'hA;
        Valid = 1'b1;
        repeat (4) tick();
        check("bounce_hold_count", fifo_count, 1);
        sb.push_back(4'hA);
        Valid = 1'b0;
        repeat (6) tick();
        drain("bounce");

        // Release bounce must not duplicate the event.
        press(4'h3, 5, 2);
        Valid = 1'b1;
        repeat (2) tick();
        Valid = 1'b0;
        repeat (6) tick();
        check("relbounce_count", fifo_count, 1);
        sb.push_back(4'h3);
        drain("relbounce");

        // Overflow: five presses into a four-entry queue.
        for (int k = 0; k < 5; k++) begin
            press(4'(k), 5, 6);
            if (k < DEPTH) sb.push_back(4'(k));
        end
        check("ovf_full", fifo_full, 1);
        check("ovf_flag", overflow, 1);
        check("ovf_count", fifo_count, 4);
        drain("ovf");
        check("ovf_sticky", overflow, 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Push and pop on the same edge while full.
        for (int k = 0; k < DEPTH; k++) begin
            press(4'(k), 5, 6);
            sb.push_back(4'(k));
        end
        check("pp_full_before", fifo_full, 1);
        Code  = 4'hF;
        Valid = 1'b1;
        repeat (3) tick();
        pop_check("pp_head");
        sb.push_back(4'hF);
        check("pp_count", fifo_count, 4);
        check("pp_ovf", overflow, 0);
        check("pp_full_after", fifo_full, 1);
        Valid = 1'b0;
        repeat (6) tick();
        drain("pp");

        // Asynchronous reset during CONFIRM with two entries queued.
        press(4'h8, 5, 6);
        press(4'h9, 5, 6);
        check("arst_count_before", fifo_count, 2);
        Code  = 4'h6;
        Valid = 1'b1;
        repeat (2) tick();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("arst");
        Valid = 1'b0;
        sb.delete();
        tick();
        reset = 1'b1;
        press(4'h5, 5, 6);
        check("arst_fresh_count", fifo_count, 1);
        sb.push_back(4'h5);
        drain("arst_fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_key_controller.md
# hex_key_controller

Sequencing and buffering controller placed downstream of `hex_keypad_scanner`. It qualifies the scanner's `Code`/`Valid` pair with a debounce counter, emits exactly one key event per physical press (with release debounce), and queues events in a small FIFO read by the consumer through a pop handshake. It lets host logic consume keys at its own pace without missing or duplicating presses.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive identical samples required to accept a press or a release; legal range 2..255.
- `FIFO_DEPTH`, 4: event queue depth; power of two, 2..16.
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `Code`  in  4  key code from scanner.
- `Valid`  in  1  scanner key-detected flag.
- `key_pop`  in  1  consumer removes head entry this cycle.
- `clear_ovf`  in  1  clears sticky overflow flag.
- `key_data`  out  4  FIFO head code; value is only meaningful while `key_avail`=1.
- `key_avail`  out  1  FIFO non-empty.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  number of entries held.
- `overflow`  out  1  sticky; a qualified press was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, CONFIRM, HELD, RELEASE; 8-bit debounce counter `cnt`; 4-bit candidate register `cand`.
- IDLE: `Valid`=1 -> `cand`<=`Code`, `cnt`<=1, go to CONFIRM. Otherwise stay in IDLE.
- CONFIRM: `Valid`=1 and `Code`==`cand` -> `cnt`++. When the incremented value reaches `DEBOUNCE_CYCLES`, issue a push and go to HELD. If `Valid`=0 or `Code`!=`cand`, go to IDLE with no push. The mismatching sample is discarded, not used as a new candidate.
- HELD: stay while `Valid`=1; any code change is ignored. `Valid`=0 -> `cnt`<=1, go to RELEASE.
- RELEASE: `Valid`=0 -> `cnt`++. When it reaches `DEBOUNCE_CYCLES`, go to IDLE. `Valid`=1 -> go to HELD with no new event, so a bounce during release never produces a duplicate.
- FIFO: circular buffer with read and write pointers, plus a count register.
  - Push writes `cand`.
  - Pop while empty is ignored.
  - Push while full is dropped and sets `overflow`, unless `key_pop` is asserted in the same cycle. In that case both the pop and the push succeed, and the count stays at `FIFO_DEPTH`.
  - Simultaneous push and pop while not empty: the count is unchanged and the data order is preserved.
  - Simultaneous push and pop while empty: the push succeeds and the pop is ignored.
- `overflow`: set by a dropped push; cleared by `clear_ovf`. If a set and a clear occur in the same cycle, the set wins.
- Pointers wrap modulo `FIFO_DEPTH`. The count never exceeds `FIFO_DEPTH` and never underflows below 0.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, `cnt`=0, `cand`=0, pointers=0. Outputs: `key_avail`=0, `fifo_full`=0, `fifo_count`=0, `overflow`=0, `key_data`=0.
- Reset mid-press discards the in-progress debounce and all queued entries.
- Reset is released synchronously to `clock`; the first sample is taken at the next rising edge.
- Press latency: the first edge sampling `Valid`=1 is edge 1. The push occurs at edge `DEBOUNCE_CYCLES`. `key_avail`/`key_data` are valid immediately after that edge when the FIFO was empty.
- Release: the earliest IDLE entry is at edge `DEBOUNCE_CYCLES` of a continuous `Valid`=0 run. The next press's edge 1 can follow on the next edge.
- Pop: `key_data` advances to the next entry immediately after the edge sampling `key_pop`=1. `key_avail` drops after that same edge if the FIFO becomes empty.
- All outputs are registered or decoded directly from registers; there is no combinational path from inputs to outputs.
- Inputs are assumed synchronous to `clock`; synchronization is done upstream by `synchronizer`.

## Test plan
- Clean press, `DEBOUNCE_CYCLES`=4: hold `Code`=4'h7, `Valid`=1 for 10 cycles, then release -> exactly one event. `key_avail` rises after edge 4; `key_data`=7; `fifo_count`=1.
- Bounce reject: `Valid` pulses of 3 cycles on, 1 off, repeated 5 times with `Code`=4'hA -> no push, `key_avail` stays 0. Then holding `Valid` for 4 cycles -> one event of 4'hA.
- Release bounce: press 4'h3 accepted, then `Valid` goes 0 for 2 cycles, 1 for 2 cycles, then 0 for 6 cycles -> one entry only, `fifo_count`=1.
- Overflow: 5 qualified presses (0, 1, 2, 3, 4) with no pop, `FIFO_DEPTH`=4 -> `fifo_full`=1, `overflow`=1, and pops return 0, 1, 2, 3 in order. Then pulse `clear_ovf` -> `overflow`=0.
- Push+pop when full: FIFO holds 0..3 and `key_pop` is asserted on the push edge of key 4'hF -> count stays 4, `overflow`=0, and the drain order is 1, 2, 3, F.
- Asynchronous reset mid-operation: assert `reset`=0 during CONFIRM with 2 entries queued -> all outputs 0 immediately, with no clock edge required. After release, a fresh press of 4'h5 yields a single entry 5.
